// File: rtl/psd_readout_pkg.sv
// Shared types, word layout and default parameters for the PSD ADC readout sequencer.
package psd_readout_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned TAG_LSB   = 24;
    localparam int unsigned BOARD_LSB = 16;
    localparam int unsigned SAMPLE_W  = 16;

    localparam int unsigned DEF_NUM_LANES    = 8;
    localparam int unsigned DEF_ADC_BITS     = 16;
    localparam int unsigned DEF_SCLK_HALF    = 4;
    localparam int unsigned DEF_CONV_CYCLES  = 8;
    localparam int unsigned DEF_QUIET_CYCLES = 4;

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        QUIET,
        SHIFT,
        EMIT,
        DONE
    } state_t;

    // Largest of three counts; sizes the shared phase counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Assemble one stream word: {tag, board_id, zero-extended sample}.
    function automatic logic [WORD_W-1:0] pack_word(input logic [7:0]          tag,
                                                    input logic [7:0]          board,
                                                    input logic [SAMPLE_W-1:0] sample);
        logic [WORD_W-1:0] w;
        w                    = '0;
        w[TAG_LSB +: 8]      = tag;
        w[BOARD_LSB +: 8]    = board;
        w[SAMPLE_W-1:0]      = sample;
        return w;
    endfunction

endpackage

// File: rtl/psd_adc_lane_shreg.sv
// One ADC lane: MSB-first serial-to-parallel shift register with synchronous clear.
module psd_adc_lane_shreg #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             sdo,
    output logic [WIDTH-1:0] q
);

    // Clear wins over shift; new bits enter at the LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {q[WIDTH-2:0], sdo};
        end
    end

endmodule

// File: rtl/psd_adc_readout_seq.sv
// PSD ADC readout sequencer: convert, shift all lanes in parallel, stream one tagged word per enabled lane.
module psd_adc_readout_seq
    import psd_readout_pkg::*;
#(
    parameter int unsigned NUM_LANES    = DEF_NUM_LANES,
    parameter int unsigned ADC_BITS     = DEF_ADC_BITS,
    parameter int unsigned SCLK_HALF    = DEF_SCLK_HALF,
    parameter int unsigned CONV_CYCLES  = DEF_CONV_CYCLES,
    parameter int unsigned QUIET_CYCLES = DEF_QUIET_CYCLES
) (
    input  logic                 mclk,
    input  logic                 mrst,
    input  logic                 start,
    input  logic [NUM_LANES-1:0] lane_mask,
    input  logic [7:0]           data_tag,
    input  logic [7:0]           board_id,
    input  logic [NUM_LANES-1:0] adc_sdo,
    output logic                 adc_conv,
    output logic                 adc_sclk,
    output logic [WORD_W-1:0]    m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 m_tlast,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);

    localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int unsigned CNT_W  = $clog2(max3(CONV_CYCLES, QUIET_CYCLES, SCLK_HALF) + 1);
    localparam int unsigned BIT_W  = $clog2(ADC_BITS + 1);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [NUM_LANES-1:0] rem_mask;
    logic [7:0]           tag_q;
    logic [7:0]           id_q;
    logic [ADC_BITS-1:0]  lane_q [NUM_LANES];

    logic                 accept_c;
    logic                 half_end_c;
    logic                 shift_en_c;
    logic [LANE_W-1:0]    sel_lane;
    logic [NUM_LANES-1:0] rem_next;
    logic [WORD_W-1:0]    sel_word;

    assign accept_c   = (state == IDLE) && start && (|lane_mask);
    assign half_end_c = (cnt == CNT_W'(SCLK_HALF - 1));
    assign shift_en_c = (state == SHIFT) && !adc_sclk && half_end_c;

    // Lane shift registers, all shifted together regardless of mask.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        psd_adc_lane_shreg #(
            .WIDTH (ADC_BITS)
        ) u_lane (
            .clk      (mclk),
            .rst_n    (mrst),
            .clr      (accept_c),
            .shift_en (shift_en_c),
            .sdo      (adc_sdo[g]),
            .q        (lane_q[g])
        );
    end

    // Priority encoder: lowest-index lane still waiting to be emitted.
    always_comb begin
        sel_lane = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (rem_mask[i]) sel_lane = LANE_W'(i);
        end
    end

    assign rem_next = rem_mask & ~(NUM_LANES'(1) << sel_lane);
    assign sel_word = pack_word(tag_q, id_q, SAMPLE_W'(lane_q[sel_lane]));

    // Sequencer FSM with registered ADC strobes and stream outputs.
    always_ff @(posedge mclk or negedge mrst) begin
        if (!mrst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            rem_mask <= '0;
            tag_q    <= '0;
            id_q     <= '0;
            adc_conv <= 1'b0;
            adc_sclk <= 1'b0;
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            done    <= 1'b0;
            overrun <= start && (state != IDLE);
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        rem_mask <= lane_mask;
                        tag_q    <= data_tag;
                        id_q     <= board_id;
                        cnt      <= '0;
                        adc_conv <= 1'b1;
                        busy     <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    if (cnt == CNT_W'(CONV_CYCLES - 1)) begin
                        cnt      <= '0;
                        adc_conv <= 1'b0;
                        state    <= QUIET;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                QUIET: begin
                    if (cnt == CNT_W'(QUIET_CYCLES - 1)) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (half_end_c) begin
                        cnt      <= '0;
                        adc_sclk <= !adc_sclk;
                        if (adc_sclk) begin
                            if (bit_cnt == BIT_W'(ADC_BITS - 1)) begin
                                m_tvalid <= 1'b1;
                                m_tdata  <= sel_word;
                                m_tlast  <= (rem_next == '0);
                                rem_mask <= rem_next;
                                state    <= EMIT;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                EMIT: begin
                    if (m_tready) begin
                        if (m_tlast) begin
                            m_tvalid <= 1'b0;
                            m_tlast  <= 1'b0;
                            m_tdata  <= '0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            m_tdata  <= sel_word;
                            m_tlast  <= (rem_next == '0);
                            rem_mask <= rem_next;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psd_adc_readout_seq.sv
// Directed bench for psd_adc_readout_seq: default 16-bit instance plus a 12-bit instance.
module tb_psd_adc_readout_seq;

    localparam int unsigned NL = 8;

    logic          mclk = 1'b0;
    logic          mrst;
    logic          start;
    logic          start12;
    logic          m_tready;
    logic [7:0]    lane_mask;
    logic [7:0]    data_tag;
    logic [7:0]    board_id;
    logic [NL-1:0] sdo;
    logic [NL-1:0] sdo12;

    logic          conv, sclk, tvalid, tlast, busy, done, overrun;
    logic [31:0]   tdata;
    logic          conv12, sclk12, tvalid12, tlast12, busy12, done12, overrun12;
    logic [31:0]   tdata12;

    int total = 0;
    int bad   = 0;
    bit rand_en = 1'b0;

    always #5 mclk = ~mclk;

    psd_adc_readout_seq dut (
        .mclk(mclk), .mrst(mrst), .start(start), .lane_mask(lane_mask),
        .data_tag(data_tag), .board_id(board_id), .adc_sdo(sdo),
        .adc_conv(conv), .adc_sclk(sclk), .m_tdata(tdata), .m_tvalid(tvalid),
        .m_tready(m_tready), .m_tlast(tlast), .busy(busy), .done(done), .overrun(overrun)
    );

    psd_adc_readout_seq #(.ADC_BITS(12)) dut12 (
        .mclk(mclk), .mrst(mrst), .start(start12), .lane_mask(lane_mask),
        .data_tag(data_tag), .board_id(board_id), .adc_sdo(sdo12),
        .adc_conv(conv12), .adc_sclk(sclk12), .m_tdata(tdata12), .m_tvalid(tvalid12),
        .m_tready(m_tready), .m_tlast(tlast12), .busy(busy12), .done(done12), .overrun(overrun12)
    );

    task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ADC models: load on conv, present MSB, advance after each sclk falling edge.
    logic [15:0] vals   [NL];
    logic [15:0] sr     [NL];
    logic [11:0] vals12 [NL];
    logic [11:0] sr12   [NL];
    logic        sclk_d   = 1'b0;
    logic        sclk12_d = 1'b0;

    always @(negedge mclk) begin
        for (int i = 0; i < NL; i++) begin
            if (conv) sr[i] <= vals[i];
            else if (sclk_d && !sclk) sr[i] <= sr[i] << 1;
            if (conv12) sr12[i] <= vals12[i];
            else if (sclk12_d && !sclk12) sr12[i] <= sr12[i] << 1;
        end
        sclk_d   <= sclk;
        sclk12_d <= sclk12;
    end

    always_comb begin
        for (int i = 0; i < NL; i++) begin
            sdo[i]   = sr[i][15];
            sdo12[i] = sr12[i][11];
        end
    end

    // Ready generator: either always ready or random stalls.
    always @(posedge mclk) begin
        #1;
        m_tready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Stream monitor: collect handshakes, verify stall stability, count pulses.
    logic [32:0] q16[$];
    logic [32:0] q12[$];
    logic [32:0] exp_q[$];
    int          done_cnt = 0;
    int          done12_cnt = 0;
    int          ovr_cnt = 0;
    logic        hold = 1'b0;
    logic [31:0] hold_d;
    logic        hold_l;

    always @(negedge mclk) begin
        if (mrst === 1'b1) begin
            if (hold) begin
                chk("stall_valid", 33'(tvalid), 33'd1);
                chk("stall_data", 33'(tdata), 33'(hold_d));
                chk("stall_last", 33'(tlast), 33'(hold_l));
            end
            hold   = tvalid && !m_tready;
            hold_d = tdata;
            hold_l = tlast;
            if (tvalid && m_tready)   q16.push_back({tlast, tdata});
            if (tvalid12 && m_tready) q12.push_back({tlast12, tdata12});
            if (done)    done_cnt++;
            if (done12)  done12_cnt++;
            if (overrun) ovr_cnt++;
        end else begin
            hold = 1'b0;
        end
    end

    task automatic do_start(input bit which, input logic [7:0] m, input logic [7:0] t,
                            input logic [7:0] id);
        @(posedge mclk); #1;
        lane_mask = m;
        data_tag  = t;
        board_id  = id;
        if (which) start12 = 1'b1;
        else       start   = 1'b1;
        @(posedge mclk); #1;
        start   = 1'b0;
        start12 = 1'b0;
    endtask

    task automatic wait_done(input bit which, input int bound);
        int c0;
        int k;
        c0 = which ? done12_cnt : done_cnt;
        k  = 0;
        while (((which ? done12_cnt : done_cnt) == c0) && k < bound) begin
            @(posedge mclk);
            k++;
        end
        chk(which ? "done12_seen" : "done_seen", 33'((which ? done12_cnt : done_cnt) - c0), 33'd1);
    endtask

    task automatic cmp_pkt(input string nm, input bit which);
        logic [32:0] g[$];
        logic [32:0] v;
        if (which) g = q12;
        else       g = q16;
        chk({nm, "_count"}, 33'(g.size()), 33'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            v = (i < g.size()) ? g[i] : '1;
            chk($sformatf("%s_word%0d", nm, i), v, exp_q[i]);
        end
    endtask

    initial begin
        int n;
        int first_rise;
        int seen;
        int d0;
        int o0;
        int k;

        mrst = 1'b0; start = 1'b0; start12 = 1'b0;
        lane_mask = '0; data_tag = '0; board_id = '0;
        for (int i = 0; i < NL; i++) begin
            vals[i]   = 16'h1000 + 16'(i);
            vals12[i] = 12'hF00 + 12'(i);
        end

        repeat (3) @(posedge mclk);
        @(negedge mclk);
        chk("rst_conv", 33'(conv), 33'd0);
        chk("rst_sclk", 33'(sclk), 33'd0);
        chk("rst_tvalid", 33'(tvalid), 33'd0);
        chk("rst_tlast", 33'(tlast), 33'd0);
        chk("rst_tdata", 33'(tdata), 33'd0);
        chk("rst_busy", 33'(busy), 33'd0);
        chk("rst_done", 33'(done), 33'd0);
        chk("rst_overrun", 33'(overrun), 33'd0);
        @(posedge mclk); #1;
        mrst = 1'b1;

        // Full 8-lane readout with timing checks.
        do_start(1'b0, 8'hFF, 8'hA5, 8'h03);
        n = 0;
        first_rise = 0;
        do begin
            @(negedge mclk);
            n++;
            if (n == 1) begin
                chk("t1_conv_rise", 33'(conv), 33'd1);
                chk("t1_busy_rise", 33'(busy), 33'd1);
            end
            if (sclk && first_rise == 0) first_rise = n;
        end while (!tvalid && n < 1000);
        chk("t1_sclk_first_rise", 33'(first_rise), 33'd17);
        chk("t1_tvalid_latency", 33'(n), 33'd141);
        wait_done(1'b0, 400);
        @(negedge mclk);
        chk("t1_busy_after", 33'(busy), 33'd0);
        repeat (3) @(negedge mclk);
        chk("t1_done_once", 33'(done_cnt), 33'd1);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), 32'hA503_1000 + 32'(i)});
        cmp_pkt("t1", 1'b0);
        chk("t1_no_overrun", 33'(ovr_cnt), 33'd0);

        // 12-bit instance, two sparse lanes.
        vals12[2] = 12'hABC;
        vals12[5] = 12'h123;
        do_start(1'b1, 8'b0010_0100, 8'h5A, 8'h7E);
        wait_done(1'b1, 400);
        exp_q.delete();
        exp_q.push_back({1'b0, 32'h5A7E_0ABC});
        exp_q.push_back({1'b1, 32'h5A7E_0123});
        cmp_pkt("t2", 1'b1);

        // Random backpressure over a sparse mask.
        for (int i = 0; i < NL; i++) vals[i] = 16'h2000 + 16'(i) * 16'h0111;
        q16.delete();
        rand_en = 1'b1;
        do_start(1'b0, 8'b1001_0110, 8'hC3, 8'h44);
        wait_done(1'b0, 2000);
        rand_en = 1'b0;
        exp_q.delete();
        exp_q.push_back({1'b0, 32'hC344_2111});
        exp_q.push_back({1'b0, 32'hC344_2222});
        exp_q.push_back({1'b0, 32'hC344_2444});
        exp_q.push_back({1'b1, 32'hC344_2777});
        cmp_pkt("t3", 1'b0);

        // Start during SHIFT: one overrun, original readout intact.
        for (int i = 0; i < NL; i++) vals[i] = 16'h1000 + 16'(i);
        q16.delete();
        o0 = ovr_cnt;
        d0 = done_cnt;
        do_start(1'b0, 8'hFF, 8'h11, 8'h22);
        repeat (40) @(negedge mclk);
        do_start(1'b0, 8'h0F, 8'hEE, 8'h99);
        repeat (4) @(negedge mclk);
        chk("t4_overrun_once", 33'(ovr_cnt - o0), 33'd1);
        wait_done(1'b0, 400);
        chk("t4_done_once", 33'(done_cnt - d0), 33'd1);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), 32'h1122_1000 + 32'(i)});
        cmp_pkt("t4", 1'b0);

        // Reset mid-EMIT after three words, then a clean readout.
        q16.delete();
        do_start(1'b0, 8'hFF, 8'hA5, 8'h03);
        k = 0;
        while (q16.size() < 3 && k < 500) begin
            @(posedge mclk);
            k++;
        end
        #1;
        mrst = 1'b0;
        d0 = done_cnt;
        @(negedge mclk);
        chk("t5_words_before", 33'(q16.size()), 33'd3);
        chk("t5_tvalid", 33'(tvalid), 33'd0);
        chk("t5_tlast", 33'(tlast), 33'd0);
        chk("t5_tdata", 33'(tdata), 33'd0);
        chk("t5_busy", 33'(busy), 33'd0);
        chk("t5_conv_sclk", 33'({conv, sclk, done, overrun}), 33'd0);
        @(posedge mclk); #1;
        mrst = 1'b1;
        repeat (3) @(negedge mclk);
        chk("t5_no_done", 33'(done_cnt - d0), 33'd0);
        q16.delete();
        do_start(1'b0, 8'hFF, 8'hA5, 8'h03);
        wait_done(1'b0, 400);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), 32'hA503_1000 + 32'(i)});
        cmp_pkt("t5", 1'b0);

        // Zero mask is ignored entirely.
        o0 = ovr_cnt;
        seen = 0;
        do_start(1'b0, 8'h00, 8'h77, 8'h01);
        for (int i = 0; i < 30; i++) begin
            @(negedge mclk);
            if (conv || busy) seen++;
        end
        chk("t6_conv_busy", 33'(seen), 33'd0);
        chk("t6_no_overrun", 33'(ovr_cnt - o0), 33'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
